// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the core controller: FSM state encoding, instruction
// word bit positions, the idle instruction word and common widths.
package core_ctrl_pkg;

   localparam int INST_W = 34;
   localparam int ADDR_W = 11;
   // Counters are one bit wider than an address so phase length plus gap fits.
   localparam int CNT_W  = 12;

   // Geometry of the 6x6 input image, 4x4 output image and 3x3 kernel.
   localparam int NIJ_ROW_W  = 6;
   localparam int ONIJ_ROW_W = 4;
   localparam int KIJ_ROW_W  = 3;

   typedef logic [ADDR_W-1:0] addr_t;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_W_L0,
      ST_W_LOAD,
      ST_X_L0,
      ST_EXEC,
      ST_DRAIN,
      ST_PSUM,
      ST_ACC,
      ST_FIN
   } state_e;

   // Instruction word bit positions.
   localparam int B_ACC      = 33;
   localparam int B_CEN_PMEM = 32;
   localparam int B_WEN_PMEM = 31;
   localparam int B_APMEM_HI = 30;
   localparam int B_APMEM_LO = 20;
   localparam int B_CEN_XMEM = 19;
   localparam int B_WEN_XMEM = 18;
   localparam int B_AXMEM_HI = 17;
   localparam int B_AXMEM_LO = 7;
   localparam int B_OFIFO_RD = 6;
   localparam int B_IFIFO_WR = 5;
   localparam int B_IFIFO_RD = 4;
   localparam int B_L0_RD    = 3;
   localparam int B_L0_WR    = 2;
   localparam int B_EXECUTE  = 1;
   localparam int B_LOAD     = 0;

   // Both memories deselected and write-disabled, every strobe low.
   localparam logic [INST_W-1:0] INST_IDLE = 34'h1_800C_0000;

endpackage

// File: rtl/core_ctrl_acc_addr.sv
// Address generator for the accumulation sequence: walks every output pixel
// and, per pixel, every kernel tap, producing the partial-sum read address,
// the read strobe, the delayed accumulate strobe and an end-of-run flag.
// Only instantiated when CORE_CTRL_ACC_SEQ_EN is defined.
module core_ctrl_acc_addr
   import core_ctrl_pkg::*;
#(
   parameter int len_nij  = 36,
   parameter int len_kij  = 9,
   parameter int len_onij = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en_i,
   output logic              rd_o,
   output logic              acc_o,
   output logic              last_o,
   output logic [ADDR_W-1:0] addr_o
);

   // A pixel slot is len_kij reads, one trailing accumulate and one idle cycle.
   localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(len_kij + 1);
   localparam logic [CNT_W-1:0] KIJ_N     = CNT_W'(len_kij);
   localparam logic [CNT_W-1:0] PIX_LAST  = CNT_W'(len_onij - 1);
   localparam logic [1:0]       KJ_LAST   = 2'(KIJ_ROW_W - 1);

   logic [CNT_W-1:0] step_q, step_d;
   logic [CNT_W-1:0] pix_q, pix_d;
   logic [CNT_W-1:0] ki_q, ki_d;
   logic [1:0]       kj_q, kj_d;

   // Next counter values: step within a pixel, kernel row/column, pixel index.
   always_comb begin
      step_d = step_q;
      pix_d  = pix_q;
      ki_d   = ki_q;
      kj_d   = kj_q;
      if (!en_i) begin
         step_d = '0;
         pix_d  = '0;
         ki_d   = '0;
         kj_d   = '0;
      end else if (step_q == STEP_LAST) begin
         step_d = '0;
         ki_d   = '0;
         kj_d   = '0;
         pix_d  = pix_q + 1'b1;
      end else begin
         step_d = step_q + 1'b1;
         if (kj_q == KJ_LAST) begin
            kj_d = '0;
            ki_d = ki_q + 1'b1;
         end else begin
            kj_d = kj_q + 1'b1;
         end
      end
   end

   // Counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         step_q <= '0;
         pix_q  <= '0;
         ki_q   <= '0;
         kj_q   <= '0;
      end else begin
         step_q <= step_d;
         pix_q  <= pix_d;
         ki_q   <= ki_d;
         kj_q   <= kj_d;
      end
   end

   assign rd_o   = en_i && (step_q < KIJ_N);
   assign acc_o  = en_i && (step_q != '0) && (step_q <= KIJ_N);
   assign last_o = en_i && (step_q == STEP_LAST) && (pix_q == PIX_LAST);

   // Tap base plus the input pixel under the kernel tap; wraps modulo 2^11.
   assign addr_o = addr_t'(step_q) * addr_t'(len_nij)
                 + (addr_t'(pix_q / CNT_W'(ONIJ_ROW_W)) + addr_t'(ki_q)) * addr_t'(NIJ_ROW_W)
                 + addr_t'(pix_q % CNT_W'(ONIJ_ROW_W)) + addr_t'(kj_q);

endmodule

// File: rtl/core_ctrl.sv
// Layer sequencer for the systolic core. For every kernel tap it loads
// weights into L0, pushes them into the array, streams the input pixels,
// executes, drains and writes the partial sums to pmem. The instruction word
// is registered, so it always describes the previous cycle's state.
// Optional macro CORE_CTRL_ACC_SEQ_EN adds the partial-sum accumulation pass
// (ACC state); without it the run ends after the last tap and acc stays 0.
module core_ctrl
   import core_ctrl_pkg::*;
#(
   parameter int row      = 8,
   parameter int col      = 8,
   parameter int len_nij  = 36,
   parameter int len_kij  = 9,
   parameter int len_onij = 16,
   parameter int gap      = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        ofifo_valid,
   output logic [33:0] inst,
   output logic        busy,
   output logic        done,
   output logic [3:0]  kij_idx
);

   localparam logic [CNT_W-1:0] LEN_COL   = CNT_W'(col);
   localparam logic [CNT_W-1:0] LEN_NIJ   = CNT_W'(len_nij);
   localparam logic [CNT_W-1:0] LEN_DRAIN = CNT_W'(row + col);
   localparam logic [CNT_W-1:0] LEN_KIJ   = CNT_W'(len_kij);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((gap > 0) ? gap - 1 : 0);
   localparam logic             GAP_EN    = (gap > 0);

`ifdef CORE_CTRL_ACC_SEQ_EN
   localparam state_e AFTER_CONV = ST_ACC;
`else
   localparam state_e AFTER_CONV = ST_FIN;
`endif

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             in_gap_q, in_gap_d;
   logic [CNT_W-1:0] kij_q, kij_d;
   logic [33:0]      inst_q, inst_d;

   logic [CNT_W-1:0] phase_len;
   logic             has_gap;
   logic             counted;
   logic             step;
   logic             leave;
   state_e           phase_next;

`ifdef CORE_CTRL_ACC_SEQ_EN
   logic              acc_rd;
   logic              acc_hi;
   logic              acc_last;
   logic [ADDR_W-1:0] acc_addr;

   core_ctrl_acc_addr #(
      .len_nij  (len_nij),
      .len_kij  (len_kij),
      .len_onij (len_onij)
   ) u_acc_addr (
      .clk    (clk),
      .reset  (reset),
      .en_i   (state_q == ST_ACC),
      .rd_o   (acc_rd),
      .acc_o  (acc_hi),
      .last_o (acc_last),
      .addr_o (acc_addr)
   );
`else
   // Output pixel count only matters to the accumulation pass.
   logic unused_cfg;
   assign unused_cfg = ^(CNT_W'(len_onij));
`endif

   // State, counters and the registered instruction word.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         in_gap_q <= 1'b0;
         kij_q    <= '0;
         inst_q   <= INST_IDLE;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         in_gap_q <= in_gap_d;
         kij_q    <= kij_d;
         inst_q   <= inst_d;
      end
   end

   // Next state: each counted phase runs its length, then optionally a gap.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      in_gap_d   = in_gap_q;
      kij_d      = kij_q;
      phase_len  = '0;
      has_gap    = 1'b0;
      counted    = 1'b0;
      step       = 1'b1;
      leave      = 1'b0;
      phase_next = state_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d  = ST_W_L0;
               cnt_d    = '0;
               in_gap_d = 1'b0;
               kij_d    = '0;
            end
         end
         ST_W_L0: begin
            counted = 1'b1; phase_len = LEN_COL; has_gap = 1'b1; phase_next = ST_W_LOAD;
         end
         ST_W_LOAD: begin
            counted = 1'b1; phase_len = LEN_COL; has_gap = 1'b1; phase_next = ST_X_L0;
         end
         ST_X_L0: begin
            counted = 1'b1; phase_len = LEN_NIJ; has_gap = 1'b1; phase_next = ST_EXEC;
         end
         ST_EXEC: begin
            counted = 1'b1; phase_len = LEN_NIJ; phase_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            counted = 1'b1; phase_len = LEN_DRAIN; phase_next = ST_PSUM;
         end
         ST_PSUM: begin
            // Writes only advance on a readable OFIFO row; the gap always counts.
            counted    = 1'b1;
            phase_len  = LEN_NIJ;
            has_gap    = 1'b1;
            step       = in_gap_q | ofifo_valid;
            phase_next = (kij_q + 1'b1 < LEN_KIJ) ? ST_W_L0 : AFTER_CONV;
         end
`ifdef CORE_CTRL_ACC_SEQ_EN
         ST_ACC: begin
            if (acc_last) state_d = ST_FIN;
         end
`endif
         ST_FIN: begin
            state_d = ST_IDLE;
            kij_d   = '0;
         end
         default: state_d = ST_IDLE;
      endcase

      if (counted && step) begin
         if (!in_gap_q) begin
            if (cnt_q == phase_len - 1'b1) begin
               cnt_d = '0;
               if (has_gap && GAP_EN) in_gap_d = 1'b1;
               else                   leave    = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end else if (cnt_q == GAP_LAST) begin
            cnt_d = '0;
            leave = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      if (leave) begin
         state_d  = phase_next;
         in_gap_d = 1'b0;
         if (state_q == ST_PSUM) kij_d = kij_q + 1'b1;
      end
   end

   // Instruction word for the current state; registered into inst_q above.
   always_comb begin
      inst_d = INST_IDLE;
      case (state_q)
         ST_W_L0: begin
            if (!in_gap_q) begin
               inst_d[B_CEN_XMEM] = 1'b0;
               inst_d[B_L0_WR]    = 1'b1;
               inst_d[B_AXMEM_HI:B_AXMEM_LO] = addr_t'(1024) + addr_t'(kij_q) * addr_t'(col)
                                             + addr_t'(cnt_q);
            end
         end
         ST_W_LOAD: begin
            if (!in_gap_q) begin
               inst_d[B_L0_RD] = 1'b1;
               inst_d[B_LOAD]  = 1'b1;
            end
         end
         ST_X_L0: begin
            if (!in_gap_q) begin
               inst_d[B_CEN_XMEM] = 1'b0;
               inst_d[B_L0_WR]    = 1'b1;
               inst_d[B_AXMEM_HI:B_AXMEM_LO] = addr_t'(cnt_q);
            end
         end
         ST_EXEC, ST_DRAIN: begin
            inst_d[B_L0_RD]   = 1'b1;
            inst_d[B_EXECUTE] = 1'b1;
         end
         ST_PSUM: begin
            if (!in_gap_q && ofifo_valid) begin
               inst_d[B_OFIFO_RD] = 1'b1;
               inst_d[B_CEN_PMEM] = 1'b0;
               inst_d[B_WEN_PMEM] = 1'b0;
               inst_d[B_APMEM_HI:B_APMEM_LO] = addr_t'(kij_q) * addr_t'(len_nij)
                                             + addr_t'(cnt_q);
            end
         end
`ifdef CORE_CTRL_ACC_SEQ_EN
         ST_ACC: begin
            if (acc_rd) begin
               inst_d[B_CEN_PMEM] = 1'b0;
               inst_d[B_APMEM_HI:B_APMEM_LO] = acc_addr;
            end
            if (acc_hi) inst_d[B_ACC] = 1'b1;
         end
`endif
         default: ;
      endcase
      // The IFIFO is not used by this sequence.
      inst_d[B_IFIFO_WR] = 1'b0;
      inst_d[B_IFIFO_RD] = 1'b0;
   end

   assign inst    = inst_q;
   assign busy    = (state_q != ST_IDLE);
   assign done    = (state_q == ST_FIN);
   assign kij_idx = kij_q[3:0];

endmodule

// File: tb/tb_core_ctrl.sv
// Self-checking bench for core_ctrl: a vector table for reset/start handling,
// hand sequences for the PSUM stall and mid-run reset, and a full run with
// random ofifo_valid against a phase-list reference model.
module tb_core_ctrl;

   localparam int ROW  = 8;
   localparam int COL  = 8;
   localparam int NIJ  = 36;
   localparam int KIJ  = 9;
   localparam int ONIJ = 16;
   localparam int GAP  = 10;
   localparam int MAXC = 5000;
   localparam logic [33:0] IDLE_W = 34'h1_800C_0000;

   logic        clk = 1'b0;
   logic        reset, start, ofifo_valid;
   logic [33:0] inst;
   logic        busy, done;
   logic [3:0]  kij_idx;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   core_ctrl #(
      .row(ROW), .col(COL), .len_nij(NIJ), .len_kij(KIJ), .len_onij(ONIJ), .gap(GAP)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .ofifo_valid(ofifo_valid),
      .inst(inst), .busy(busy), .done(done), .kij_idx(kij_idx)
   );

   typedef struct {
      bit          rst;
      bit          st;
      bit          vld;
      bit          e_busy;
      bit          e_done;
      logic [33:0] e_inst;
   } vec_t;

   vec_t        tbl [10];
   bit          vld [MAXC];
   logic [33:0] exp_inst [$];
   int          exp_kij [$];

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [33:0] w_xmem(logic [10:0] a);
      logic [33:0] w;
      w = IDLE_W; w[19] = 1'b0; w[2] = 1'b1; w[17:7] = a;
      return w;
   endfunction

   function automatic logic [33:0] w_psum(logic [10:0] a);
      logic [33:0] w;
      w = IDLE_W; w[6] = 1'b1; w[32] = 1'b0; w[31] = 1'b0; w[30:20] = a;
      return w;
   endfunction

   function automatic logic [33:0] w_load();
      logic [33:0] w;
      w = IDLE_W; w[3] = 1'b1; w[0] = 1'b1;
      return w;
   endfunction

   function automatic logic [33:0] w_exec();
      logic [33:0] w;
      w = IDLE_W; w[3] = 1'b1; w[1] = 1'b1;
      return w;
   endfunction

   function automatic void push(logic [33:0] w, int k);
      exp_inst.push_back(w);
      exp_kij.push_back(k);
   endfunction

   // Expected per-cycle instruction list built phase by phase from the rules.
   function automatic void build_model();
      int n, cyc, a;
      logic [33:0] w;
      exp_inst.delete();
      exp_kij.delete();
      for (int k = 0; k < KIJ; k++) begin
         for (int i = 0; i < COL; i++) push(w_xmem(11'(1024 + k * COL + i)), k);
         for (int i = 0; i < GAP; i++) push(IDLE_W, k);
         for (int i = 0; i < COL; i++) push(w_load(), k);
         for (int i = 0; i < GAP; i++) push(IDLE_W, k);
         for (int i = 0; i < NIJ; i++) push(w_xmem(11'(i)), k);
         for (int i = 0; i < GAP; i++) push(IDLE_W, k);
         for (int i = 0; i < NIJ + ROW + COL; i++) push(w_exec(), k);
         n = 0;
         while (n < NIJ) begin
            cyc = exp_inst.size() + 1;
            if (cyc >= MAXC || vld[cyc]) begin
               push(w_psum(11'((k * NIJ + n) % 2048)), k);
               n++;
            end else begin
               push(IDLE_W, k);
            end
         end
         for (int i = 0; i < GAP; i++) push(IDLE_W, k);
      end
`ifdef CORE_CTRL_ACC_SEQ_EN
      for (int o = 0; o < ONIJ; o++) begin
         for (int t = 0; t < KIJ + 2; t++) begin
            w = IDLE_W;
            if (t < KIJ) begin
               a = t * NIJ + (o / 4 + t / 3) * 6 + (o % 4 + t % 3);
               w[32] = 1'b0;
               w[30:20] = 11'(a % 2048);
            end
            if (t >= 1 && t <= KIJ) w[33] = 1'b1;
            push(w, -1);
         end
      end
`endif
      push(IDLE_W, -1);
   endfunction

   task automatic do_reset();
      reset = 1'b1; start = 1'b0; ofifo_valid = 1'b0;
      tick(); tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic run_table();
      tbl[0] = '{1, 1, 0, 0, 0, IDLE_W};
      tbl[1] = '{0, 0, 0, 0, 0, IDLE_W};
      tbl[2] = '{0, 1, 0, 1, 0, IDLE_W};
      tbl[3] = '{0, 0, 0, 1, 0, w_xmem(11'd1024)};
      tbl[4] = '{0, 1, 0, 1, 0, w_xmem(11'd1025)};
      tbl[5] = '{0, 0, 0, 1, 0, w_xmem(11'd1026)};
      tbl[6] = '{1, 0, 0, 0, 0, IDLE_W};
      tbl[7] = '{0, 0, 0, 0, 0, IDLE_W};
      tbl[8] = '{1, 1, 1, 0, 0, IDLE_W};
      tbl[9] = '{0, 0, 0, 0, 0, IDLE_W};
      for (int i = 0; i < 10; i++) begin
         reset = tbl[i].rst; start = tbl[i].st; ofifo_valid = tbl[i].vld;
         tick();
         $display("vec %0d: reset=%0b start=%0b inst=%0h busy=%0b", i, reset, start, inst, busy);
         chk("tbl_inst", 64'(inst), 64'(tbl[i].e_inst));
         chk("tbl_busy", 64'(busy), 64'(tbl[i].e_busy));
         chk("tbl_done", 64'(done), 64'(tbl[i].e_done));
         chk("tbl_kij", 64'(kij_idx), 64'(0));
      end
      reset = 1'b0; start = 1'b0;
   endtask

   task automatic psum_stall();
      int p0, wr;
      logic [33:0] e;
      bit pat [4];
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
      p0 = 1 + 2 * COL + 2 * NIJ + 3 * GAP + ROW + COL;
      wr = 0;
      do_reset();
      start = 1'b1; ofifo_valid = 1'b1;
      for (int m = 1; m <= p0 + 8; m++) begin
         tick();
         start = 1'b0;
         if (m == p0) chk("psum_busy", 64'(busy), 64'(1));
         if (m > p0) begin
            e = IDLE_W;
            if (m == p0 + 1) e = w_psum(11'd0);
            if (m == p0 + 4) e = w_psum(11'd1);
            $display("psum stall cycle %0d: inst=%0h", m - p0, inst);
            chk("psum_stall_inst", 64'(inst), 64'(e));
            if (inst[32] == 1'b0 && inst[31] == 1'b0) wr++;
         end
         if (m >= p0 && m <= p0 + 3) ofifo_valid = pat[m - p0];
         else if (m > p0 + 3)        ofifo_valid = 1'b0;
         else                        ofifo_valid = 1'b1;
      end
      chk("psum_write_count", 64'(wr), 64'(2));
   endtask

   task automatic exec_reset();
      int e5, viol;
      e5 = 1 + 2 * COL + NIJ + 3 * GAP + 5;
      do_reset();
      start = 1'b1; ofifo_valid = 1'b1;
      for (int m = 1; m <= e5; m++) begin
         tick();
         start = 1'b0;
      end
      chk("exec_inst_before_reset", 64'(inst), 64'(w_exec()));
      reset = 1'b1;
      tick();
      $display("reset in EXEC: inst=%0h busy=%0b", inst, busy);
      chk("exec_reset_inst", 64'(inst), 64'(IDLE_W));
      chk("exec_reset_busy", 64'(busy), 64'(0));
      chk("exec_reset_kij", 64'(kij_idx), 64'(0));
      reset = 1'b0;
      viol = 0;
      for (int m = 0; m < 300; m++) begin
         tick();
         if (inst !== IDLE_W || busy !== 1'b0) viol++;
      end
      chk("strobes_after_reset", 64'(viol), 64'(0));
   endtask

   task automatic run_random();
      int f, done_cnt, acc_cnt, first_rd, first_acc;
      logic [33:0] e;
      logic [10:0] rd_q [$];
      int exp_rd [9];
      exp_rd = '{0, 37, 74, 114, 151, 188, 228, 265, 302};
      for (int i = 0; i < MAXC; i++) vld[i] = ($urandom_range(0, 3) != 0);
      build_model();
      f = exp_inst.size();
      done_cnt = 0; acc_cnt = 0; first_rd = -1; first_acc = -1;
      do_reset();
      start = 1'b1; ofifo_valid = vld[0];
      for (int m = 1; m <= f + 3; m++) begin
         tick();
         e = (m >= 2 && m - 2 < f) ? exp_inst[m - 2] : IDLE_W;
         chk("run_inst", 64'(inst), 64'(e));
         chk("run_busy", 64'(busy), 64'(m <= f));
         chk("run_done", 64'(done), 64'(m == f));
         if (m > f) chk("run_kij_idle", 64'(kij_idx), 64'(0));
         else if (exp_kij[m - 1] >= 0) chk("run_kij", 64'(kij_idx), 64'(exp_kij[m - 1]));
         if (done) done_cnt++;
         if (inst[33]) begin
            acc_cnt++;
            if (first_acc < 0) first_acc = m;
         end
         if (inst[32] == 1'b0 && inst[31] == 1'b1) begin
            rd_q.push_back(inst[30:20]);
            if (first_rd < 0) first_rd = m;
         end
         start = 1'b0;
         ofifo_valid = vld[m];
      end
      $display("full run: %0d cycles, done pulses %0d, acc cycles %0d", f, done_cnt, acc_cnt);
      chk("done_pulses", 64'(done_cnt), 64'(1));
`ifdef CORE_CTRL_ACC_SEQ_EN
      chk("acc_cycles", 64'(acc_cnt), 64'(ONIJ * KIJ));
      chk("acc_rd_count", 64'(rd_q.size()), 64'(ONIJ * KIJ));
      for (int i = 0; i < 9 && i < rd_q.size(); i++) begin
         $display("acc pixel0 read %0d: addr=%0d", i, rd_q[i]);
         chk("acc_rd_addr", 64'(rd_q[i]), 64'(exp_rd[i]));
      end
      chk("acc_after_read", 64'(first_acc - first_rd), 64'(1));
`else
      chk("acc_cycles", 64'(acc_cnt), 64'(0));
      chk("pmem_reads", 64'(rd_q.size()), 64'(0));
      chk("no_rd_ref", 64'(exp_rd[0]), 64'(first_rd + 1));
`endif
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; start = 1'b0; ofifo_valid = 1'b0;
      run_table();
      psum_stall();
      exec_reset();
      run_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
